// File: rtl/pipe_stage_skid.sv
// Handshaked pipeline register carrying a DATA_W payload between two stages.
// SKID_EN=1 adds a second entry so up_ready comes straight from a flop.
module pipe_stage_skid #(
  parameter int unsigned       DATA_W    = 32,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter bit                SKID_EN   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [DATA_W-1:0] up_data,
  output logic              dn_valid,
  input  logic              dn_ready,
  output logic [DATA_W-1:0] dn_data,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              ready_q, ready_d;
  logic              up_fire, dn_fire;

  assign dn_valid  = (state_q != S_EMPTY);
  assign dn_data   = main_q;
  assign occupancy = state_q;
  assign up_fire   = up_valid & up_ready;
  assign dn_fire   = dn_valid & dn_ready;

  always_comb begin
    if (SKID_EN) up_ready = ready_q;
    else         up_ready = !dn_valid | dn_ready;
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = S_EMPTY;
      main_d  = RESET_VAL;
      skid_d  = RESET_VAL;
    end else begin
      unique case (state_q)
        S_EMPTY: begin
          if (up_fire) begin
            state_d = S_ONE;
            main_d  = up_data;
          end
        end
        S_ONE: begin
          if (up_fire && dn_fire) begin
            main_d = up_data;
          end else if (up_fire) begin
            // Without the skid, up_fire in ONE implies dn_fire, so this is skid-only.
            state_d = S_TWO;
            skid_d  = up_data;
          end else if (dn_fire) begin
            state_d = S_EMPTY;
          end
        end
        S_TWO: begin
          if (dn_fire) begin
            state_d = S_ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
    ready_d = (state_d != S_TWO);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_EMPTY;
      main_q  <= RESET_VAL;
      skid_q  <= RESET_VAL;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      ready_q <= ready_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed and scoreboard checks for pipe_stage_skid: a 32-bit skid instance
// and an 8-bit pass-through (SKID_EN=0) instance sharing clock and reset.
module tb_pipe_stage_skid;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        up_valid, up_ready, dn_valid, dn_ready;
  logic [31:0] up_data, dn_data;
  logic [1:0]  occupancy;

  logic        s_flush, s_up_valid, s_up_ready, s_dn_valid, s_dn_ready;
  logic [7:0]  s_up_data, s_dn_data;
  logic [1:0]  s_occupancy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(32), .RESET_VAL(32'h0), .SKID_EN(1'b1)) u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .up_valid(up_valid), .up_ready(up_ready), .up_data(up_data),
    .dn_valid(dn_valid), .dn_ready(dn_ready), .dn_data(dn_data),
    .occupancy(occupancy)
  );

  pipe_stage_skid #(.DATA_W(8), .RESET_VAL(8'h0), .SKID_EN(1'b0)) u_dut8 (
    .clk(clk), .rst(rst), .flush(s_flush),
    .up_valid(s_up_valid), .up_ready(s_up_ready), .up_data(s_up_data),
    .dn_valid(s_dn_valid), .dn_ready(s_dn_ready), .dn_data(s_dn_data),
    .occupancy(s_occupancy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 0; up_valid = 0; dn_ready = 0; up_data = '0;
    s_flush = 0; s_up_valid = 0; s_dn_ready = 0; s_up_data = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst = 0;
    step();
    step();
    rst = 1;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 0;
    up_valid = 1; up_data = 32'hAAAA5555;
    step();
    step();
    checks++;
    if (dn_valid !== 1'b0) begin errors++; $display("FAIL reset_dn_valid got %b want 0", dn_valid); end
    checks++;
    if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occupancy got %0d want 0", occupancy); end
    checks++;
    if (dn_data !== 32'h0) begin errors++; $display("FAIL reset_dn_data got %h want 0", dn_data); end
    checks++;
    if (up_ready !== 1'b1) begin errors++; $display("FAIL reset_up_ready got %b want 1", up_ready); end
    up_valid = 0;
    rst = 1;
    #1;
  endtask

  task automatic test_fill();
    up_valid = 1; up_data = 32'hDEADBEEF; dn_ready = 1;
    step();
    up_valid = 0;
    checks++;
    if (dn_valid !== 1'b1) begin errors++; $display("FAIL fill_dn_valid got %b want 1", dn_valid); end
    checks++;
    if (dn_data !== 32'hDEADBEEF) begin errors++; $display("FAIL fill_dn_data got %h want deadbeef", dn_data); end
    step();
    checks++;
    if (dn_valid !== 1'b0) begin errors++; $display("FAIL fill_drain_dn_valid got %b want 0", dn_valid); end
  endtask

  task automatic test_backpressure();
    dn_ready = 0;
    up_valid = 1; up_data = 32'h11;
    step();
    checks++;
    if (occupancy !== 2'd1 || up_ready !== 1'b1)
      begin errors++; $display("FAIL bp_one got occ=%0d rdy=%b want occ=1 rdy=1", occupancy, up_ready); end
    up_data = 32'h22;
    step();
    up_valid = 0;
    checks++;
    if (occupancy !== 2'd2) begin errors++; $display("FAIL bp_two_occ got %0d want 2", occupancy); end
    checks++;
    if (up_ready !== 1'b0) begin errors++; $display("FAIL bp_two_up_ready got %b want 0", up_ready); end
    checks++;
    if (dn_data !== 32'h11) begin errors++; $display("FAIL bp_two_dn_data got %h want 11", dn_data); end
    step();
    checks++;
    if (dn_data !== 32'h11 || dn_valid !== 1'b1 || occupancy !== 2'd2)
      begin errors++; $display("FAIL bp_hold got data=%h v=%b occ=%0d want 11 1 2", dn_data, dn_valid, occupancy); end
    dn_ready = 1;
    step();
    checks++;
    if (dn_data !== 32'h22 || occupancy !== 2'd1)
      begin errors++; $display("FAIL bp_drain1 got data=%h occ=%0d want 22 1", dn_data, occupancy); end
    checks++;
    if (up_ready !== 1'b1) begin errors++; $display("FAIL bp_drain1_up_ready got %b want 1", up_ready); end
    step();
    checks++;
    if (dn_valid !== 1'b0 || occupancy !== 2'd0)
      begin errors++; $display("FAIL bp_drain2 got v=%b occ=%0d want 0 0", dn_valid, occupancy); end
    dn_ready = 0;
  endtask

  task automatic test_streaming();
    dn_ready = 1; up_valid = 1;
    for (int i = 1; i <= 100; i++) begin
      up_data = i;
      step();
      checks++;
      if (dn_valid !== 1'b1 || dn_data !== 32'(i) || occupancy !== 2'd1) begin
        errors++;
        $display("FAIL stream_%0d got v=%b data=%0d occ=%0d want 1 %0d 1", i, dn_valid, dn_data, occupancy, i);
      end
    end
    up_valid = 0;
    step();
    checks++;
    if (dn_valid !== 1'b0) begin errors++; $display("FAIL stream_end_dn_valid got %b want 0", dn_valid); end
    dn_ready = 0;
  endtask

  task automatic test_random();
    logic [31:0] sb[$];
    logic        held, uf, df;
    logic [31:0] held_data;
    int          mism = 0;
    int          xfers = 0;
    held = 0; held_data = '0;
    for (int c = 0; c < 10000; c++) begin
      up_valid = ($urandom_range(0, 3) != 0);
      dn_ready = ($urandom_range(0, 2) != 0);
      up_data  = $urandom;
      #1;
      checks++;
      if (dn_valid !== (sb.size() != 0) || occupancy !== 2'(sb.size()) || up_ready !== (sb.size() < 2)) begin
        errors++; mism++;
        if (mism < 10)
          $display("FAIL rand_state_c%0d got v=%b occ=%0d rdy=%b want occ=%0d", c, dn_valid, occupancy, up_ready, sb.size());
      end
      if (sb.size() != 0) begin
        checks++;
        if (dn_data !== sb[0]) begin
          errors++; mism++;
          if (mism < 10) $display("FAIL rand_data_c%0d got %h want %h", c, dn_data, sb[0]);
        end
      end
      if (held) begin
        checks++;
        if (dn_data !== held_data || dn_valid !== 1'b1) begin
          errors++; mism++;
          if (mism < 10) $display("FAIL rand_stable_c%0d got %h want %h", c, dn_data, held_data);
        end
      end
      uf = up_valid & up_ready;
      df = dn_valid & dn_ready;
      held = dn_valid & !dn_ready;
      held_data = dn_data;
      if (df && sb.size() != 0) begin void'(sb.pop_front()); xfers++; end
      if (uf) sb.push_back(up_data);
      step();
    end
    up_valid = 0; dn_ready = 1;
    while (sb.size() != 0) begin
      #1;
      checks++;
      if (dn_valid !== 1'b1 || dn_data !== sb[0])
        begin errors++; $display("FAIL rand_tail got v=%b data=%h want 1 %h", dn_valid, dn_data, sb[0]); end
      void'(sb.pop_front());
      xfers++;
      step();
    end
    checks++;
    if (dn_valid !== 1'b0 || xfers == 0)
      begin errors++; $display("FAIL rand_final got v=%b xfers=%0d want 0 >0", dn_valid, xfers); end
    dn_ready = 0;
  endtask

  task automatic test_flush();
    dn_ready = 0; up_valid = 1;
    up_data = 32'hA1; step();
    up_data = 32'hB2; step();
    checks++;
    if (occupancy !== 2'd2) begin errors++; $display("FAIL flush_pre_occ got %0d want 2", occupancy); end
    flush = 1; up_data = 32'hBAD0BAD0;
    step();
    flush = 0; up_valid = 0;
    checks++;
    if (occupancy !== 2'd0 || dn_valid !== 1'b0)
      begin errors++; $display("FAIL flush_two got occ=%0d v=%b want 0 0", occupancy, dn_valid); end
    checks++;
    if (dn_data !== 32'h0) begin errors++; $display("FAIL flush_two_data got %h want 0", dn_data); end
    checks++;
    if (up_ready !== 1'b1) begin errors++; $display("FAIL flush_two_up_ready got %b want 1", up_ready); end
    // Flush in ONE with concurrent up_fire and dn_fire: the incoming word is dropped.
    up_valid = 1; up_data = 32'hC3; step();
    up_data = 32'hD4; dn_ready = 1; flush = 1;
    step();
    flush = 0; up_valid = 0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (dn_valid !== 1'b0 || occupancy !== 2'd0)
        begin errors++; $display("FAIL flush_one_c%0d got v=%b data=%h want v=0", k, dn_valid, dn_data); end
      step();
    end
    dn_ready = 0;
  endtask

  task automatic test_async_reset();
    up_valid = 1; up_data = 32'h5A5A; step();
    up_valid = 0;
    #2;
    rst = 0;
    #1;
    checks++;
    if (dn_valid !== 1'b0 || occupancy !== 2'd0 || dn_data !== 32'h0)
      begin errors++; $display("FAIL async_reset got v=%b occ=%0d data=%h want 0 0 0", dn_valid, occupancy, dn_data); end
    rst = 1;
    #1;
  endtask

  task automatic test_noskid();
    s_dn_ready = 0; s_up_valid = 1; s_up_data = 8'h5A;
    step();
    s_up_valid = 0;
    #1;
    checks++;
    if (s_dn_valid !== 1'b1 || s_dn_data !== 8'h5A || s_occupancy !== 2'd1)
      begin errors++; $display("FAIL ns_held got v=%b data=%h occ=%0d want 1 5a 1", s_dn_valid, s_dn_data, s_occupancy); end
    checks++;
    if (s_up_ready !== 1'b0) begin errors++; $display("FAIL ns_ready_low got %b want 0", s_up_ready); end
    s_dn_ready = 1;
    #1;
    checks++;
    if (s_up_ready !== 1'b1) begin errors++; $display("FAIL ns_ready_comb got %b want 1", s_up_ready); end
    s_up_valid = 1; s_up_data = 8'h7E;
    step();
    checks++;
    if (s_dn_data !== 8'h7E || s_occupancy !== 2'd1)
      begin errors++; $display("FAIL ns_pass1 got data=%h occ=%0d want 7e 1", s_dn_data, s_occupancy); end
    s_up_data = 8'h81;
    step();
    checks++;
    if (s_dn_data !== 8'h81 || s_occupancy !== 2'd1 || s_dn_valid !== 1'b1)
      begin errors++; $display("FAIL ns_pass2 got data=%h occ=%0d want 81 1", s_dn_data, s_occupancy); end
    s_dn_ready = 0; s_up_data = 8'h33;
    #1;
    checks++;
    if (s_up_ready !== 1'b0) begin errors++; $display("FAIL ns_stall_ready got %b want 0", s_up_ready); end
    step();
    checks++;
    if (s_dn_data !== 8'h81 || s_occupancy !== 2'd1)
      begin errors++; $display("FAIL ns_stall_hold got data=%h occ=%0d want 81 1", s_dn_data, s_occupancy); end
    s_up_valid = 0; s_dn_ready = 1;
    step();
    checks++;
    if (s_dn_valid !== 1'b0 || s_occupancy !== 2'd0)
      begin errors++; $display("FAIL ns_drain got v=%b occ=%0d want 0 0", s_dn_valid, s_occupancy); end
    s_dn_ready = 0;
  endtask

  initial begin
    idle_inputs();
    rst = 0;
    #2;
    test_reset();
    test_fill();
    test_backpressure();
    test_streaming();
    apply_reset();
    test_random();
    apply_reset();
    test_flush();
    test_async_reset();
    apply_reset();
    test_noskid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
